// File: rtl/sdram_responder.sv
// SDRAM device emulator: decodes the controller command bus, tracks per-bank open rows,
// stores data in an on-chip array and returns reads after the programmed CAS latency.
module sdram_responder #(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 4
) (
    input  logic        iclk,
    input  logic        ireset,
    input  logic        DRAM_CKE,
    input  logic        DRAM_CS_N,
    input  logic        DRAM_RAS_N,
    input  logic        DRAM_CAS_N,
    input  logic        DRAM_WE_N,
    input  logic [1:0]  DRAM_BA,
    input  logic [12:0] DRAM_ADDR,
    input  logic        DRAM_LDQM,
    input  logic        DRAM_UDQM,
    input  logic [15:0] dq_write,
    output logic [15:0] dq_read,
    output logic        odq_valid,
    output logic        oerror,
    output logic [1:0]  ocas_latency
);

    localparam int IDX_BITS = 2 + ROW_BITS + COL_BITS;
    localparam int DEPTH    = 1 << IDX_BITS;

    // {RAS_N, CAS_N, WE_N}
    localparam logic [2:0] CMD_NOP       = 3'b111;
    localparam logic [2:0] CMD_ACTIVE    = 3'b011;
    localparam logic [2:0] CMD_READ      = 3'b101;
    localparam logic [2:0] CMD_WRITE     = 3'b100;
    localparam logic [2:0] CMD_PRECHARGE = 3'b010;
    localparam logic [2:0] CMD_REFRESH   = 3'b001;
    localparam logic [2:0] CMD_LOAD_MODE = 3'b000;

    logic [15:0]         mem [DEPTH];
    logic [3:0]          bank_open;
    logic [ROW_BITS-1:0] open_row [4];
    logic [1:0]          cas_latency;
    logic [2:0]          pipe_valid;
    logic [15:0]         pipe_data [3];

    logic [2:0]          cmd;
    logic                bank_is_open;
    logic                any_open;
    logic [IDX_BITS-1:0] idx;
    logic [2:0]          mode_cl;
    logic                mode_ok;
    logic                unused_bits;

    assign unused_bits  = ^DRAM_ADDR;
    assign ocas_latency = cas_latency;

    // NOTE: combinational decode uses blocking assignments with a default first, so no latch is inferred.
    always_comb begin
        cmd          = CMD_NOP;
        if (!DRAM_CS_N) begin
            cmd = {DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N};
        end
        bank_is_open = bank_open[DRAM_BA];
        any_open     = |bank_open;
        idx          = {DRAM_BA, open_row[DRAM_BA], DRAM_ADDR[COL_BITS-1:0]};
        mode_cl      = DRAM_ADDR[6:4];
        mode_ok      = (mode_cl == 3'd2) || (mode_cl == 3'd3);
    end

    // NOTE: the storage array has no reset; contents survive ireset and start undefined.
    always_ff @(posedge iclk) begin
        if (!ireset && DRAM_CKE && cmd == CMD_WRITE && bank_is_open) begin
            if (!DRAM_LDQM) mem[idx][7:0]  <= dq_write[7:0];
            if (!DRAM_UDQM) mem[idx][15:8] <= dq_write[15:8];
        end
    end

    // NOTE: sequential state uses non-blocking assignments; later assignments to the same bit win.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            bank_open   <= '0;
            cas_latency <= 2'd3;
            pipe_valid  <= '0;
            dq_read     <= '0;
            odq_valid   <= 1'b0;
            oerror      <= 1'b0;
            for (int i = 0; i < 3; i++) pipe_data[i] <= '0;
            for (int b = 0; b < 4; b++) open_row[b] <= '0;
        end else if (DRAM_CKE) begin
            pipe_valid   <= {1'b0, pipe_valid[2:1]};
            pipe_data[0] <= pipe_data[1];
            pipe_data[1] <= pipe_data[2];
            pipe_data[2] <= '0;
            odq_valid    <= pipe_valid[0];
            dq_read      <= pipe_valid[0] ? pipe_data[0] : '0;

            case (cmd)
                CMD_ACTIVE: begin
                    if (bank_is_open) oerror <= 1'b1;
                    bank_open[DRAM_BA] <= 1'b1;
                    open_row[DRAM_BA]  <= DRAM_ADDR[ROW_BITS-1:0];
                end
                CMD_READ: begin
                    // Slot CL-1 reaches stage 0 after CL-1 shifts, then the output register.
                    if (!bank_is_open) begin
                        oerror <= 1'b1;
                    end else if (cas_latency == 2'd2) begin
                        pipe_valid[1] <= 1'b1;
                        pipe_data[1]  <= mem[idx];
                    end else begin
                        pipe_valid[2] <= 1'b1;
                        pipe_data[2]  <= mem[idx];
                    end
                end
                CMD_WRITE: begin
                    if (!bank_is_open) oerror <= 1'b1;
                end
                CMD_PRECHARGE: begin
                    if (DRAM_ADDR[10]) bank_open <= '0;
                    else               bank_open[DRAM_BA] <= 1'b0;
                end
                CMD_REFRESH: begin
                    if (any_open) oerror <= 1'b1;
                end
                CMD_LOAD_MODE: begin
                    if (any_open || !mode_ok) oerror <= 1'b1;
                    else                      cas_latency <= mode_cl[1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: data path, CAS latency, byte masks,
// protocol errors, clock-enable freeze and reset of in-flight reads.
module tb_sdram_responder;

    localparam logic [2:0] ACT = 3'b011;
    localparam logic [2:0] RD  = 3'b101;
    localparam logic [2:0] WR  = 3'b100;
    localparam logic [2:0] PRE = 3'b010;
    localparam logic [2:0] LMR = 3'b000;

    logic        iclk = 1'b0;
    logic        ireset = 1'b1;
    logic        DRAM_CKE = 1'b1;
    logic        DRAM_CS_N = 1'b1;
    logic        DRAM_RAS_N = 1'b1;
    logic        DRAM_CAS_N = 1'b1;
    logic        DRAM_WE_N = 1'b1;
    logic [1:0]  DRAM_BA = '0;
    logic [12:0] DRAM_ADDR = '0;
    logic        DRAM_LDQM = 1'b0;
    logic        DRAM_UDQM = 1'b0;
    logic [15:0] dq_write = '0;
    logic [15:0] dq_read;
    logic        odq_valid;
    logic        oerror;
    logic [1:0]  ocas_latency;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_edge;
    int e0;
    logic [15:0] vq[$];
    int          cq[$];

    sdram_responder dut (
        .iclk(iclk), .ireset(ireset), .DRAM_CKE(DRAM_CKE),
        .DRAM_CS_N(DRAM_CS_N), .DRAM_RAS_N(DRAM_RAS_N), .DRAM_CAS_N(DRAM_CAS_N),
        .DRAM_WE_N(DRAM_WE_N), .DRAM_BA(DRAM_BA), .DRAM_ADDR(DRAM_ADDR),
        .DRAM_LDQM(DRAM_LDQM), .DRAM_UDQM(DRAM_UDQM), .dq_write(dq_write),
        .dq_read(dq_read), .odq_valid(odq_valid), .oerror(oerror),
        .ocas_latency(ocas_latency)
    );

    always #5 iclk = ~iclk;
    always @(posedge iclk) cyc <= cyc + 1;

    // Every read result seen on the outputs, with the edge number that produced it.
    always @(negedge iclk) begin
        if (odq_valid) begin
            vq.push_back(dq_read);
            cq.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic cmd(input logic [2:0] rcw, input logic [1:0] ba, input logic [12:0] addr,
                       input logic [15:0] d = 16'h0, input logic lm = 1'b0, input logic um = 1'b0);
        DRAM_CS_N = 1'b0;
        {DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} = rcw;
        DRAM_BA = ba;
        DRAM_ADDR = addr;
        dq_write = d;
        DRAM_LDQM = lm;
        DRAM_UDQM = um;
        tick();
        last_edge = cyc;
        DRAM_CS_N = 1'b1;
        {DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} = 3'b111;
        DRAM_LDQM = 1'b0;
        DRAM_UDQM = 1'b0;
    endtask

    task automatic do_reset();
        ireset = 1'b1;
        tick();
        tick();
        ireset = 1'b0;
    endtask

    task automatic clear_log();
        vq.delete();
        cq.delete();
    endtask

    initial begin
        // Reset state and CL=3 data path
        #1;
        do_reset();
        check("rst oerror", oerror, 0);
        check("rst valid", odq_valid, 0);
        check("rst dq", dq_read, 0);
        check("rst cl", ocas_latency, 3);

        cmd(ACT, 0, 0);
        for (int i = 0; i < 5; i++) cmd(WR, 0, 13'(i), 16'(19 + i));
        clear_log();
        for (int i = 0; i < 5; i++) begin
            cmd(RD, 0, 13'(i));
            if (i == 0) e0 = last_edge;
        end
        repeat (5) tick();
        check("cl3 count", vq.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < vq.size()) begin
                check("cl3 data", vq[i], 19 + i);
                check("cl3 edge", cq[i], e0 + 3 + i);
            end
        end
        check("cl3 oerror", oerror, 0);

        // CL=2 after LOAD MODE with banks closed
        cmd(PRE, 0, 13'h400);
        cmd(LMR, 0, 13'h020);
        check("lmr cl2", ocas_latency, 2);
        cmd(ACT, 0, 0);
        for (int i = 0; i < 5; i++) cmd(WR, 0, 13'(i), 16'(50 + i));
        clear_log();
        for (int i = 0; i < 5; i++) begin
            cmd(RD, 0, 13'(i));
            if (i == 0) e0 = last_edge;
        end
        repeat (5) tick();
        check("cl2 count", vq.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < vq.size()) begin
                check("cl2 data", vq[i], 50 + i);
                check("cl2 edge", cq[i], e0 + 2 + i);
            end
        end
        check("cl2 oerror", oerror, 0);

        // Illegal mode value is rejected and flagged
        cmd(PRE, 0, 13'h400);
        cmd(LMR, 0, 13'h050);
        check("lmr bad err", oerror, 1);
        check("lmr bad cl", ocas_latency, 2);
        do_reset();
        check("rst2 oerror", oerror, 0);
        check("rst2 cl", ocas_latency, 3);

        // Byte masks, read directly after write
        cmd(ACT, 1, 13'd2);
        cmd(WR, 1, 13'd7, 16'hA5C3);
        cmd(WR, 1, 13'd7, 16'hFFFF, 1'b1, 1'b0);
        clear_log();
        cmd(RD, 1, 13'd7);
        repeat (4) tick();
        cmd(WR, 1, 13'd7, 16'h0000, 1'b0, 1'b1);
        cmd(RD, 1, 13'd7);
        repeat (4) tick();
        check("dqm count", vq.size(), 2);
        if (vq.size() > 0) check("ldqm data", vq[0], 16'hFFC3);
        if (vq.size() > 1) check("udqm data", vq[1], 16'hFF00);
        check("dqm oerror", oerror, 0);

        // READ to a closed bank
        clear_log();
        cmd(RD, 2, 13'd0);
        repeat (5) tick();
        check("rd closed err", oerror, 1);
        check("rd closed pulse", vq.size(), 0);

        // ACTIVE on an already open bank
        do_reset();
        cmd(ACT, 0, 13'd1);
        check("act once err", oerror, 0);
        cmd(ACT, 0, 13'd1);
        check("act twice err", oerror, 1);

        // Clock-enable freeze: one enabled edge, four frozen, two more enabled
        do_reset();
        cmd(ACT, 3, 13'd0);
        cmd(WR, 3, 13'd3, 16'h1234);
        cmd(RD, 3, 13'd3);
        tick();
        DRAM_CKE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("frz valid", odq_valid, 0);
        end
        DRAM_CKE = 1'b1;
        tick();
        check("frz en1 valid", odq_valid, 0);
        tick();
        check("frz en2 valid", odq_valid, 1);
        check("frz en2 data", dq_read, 16'h1234);
        DRAM_CKE = 1'b0;
        tick();
        tick();
        check("frz hold valid", odq_valid, 1);
        check("frz hold data", dq_read, 16'h1234);
        DRAM_CKE = 1'b1;
        tick();
        check("frz drop valid", odq_valid, 0);
        check("frz drop data", dq_read, 0);

        // Reset drops an in-flight read and closes banks
        cmd(ACT, 0, 13'd0);
        clear_log();
        cmd(RD, 0, 13'd0);
        ireset = 1'b1;
        tick();
        ireset = 1'b0;
        repeat (5) tick();
        check("rst drop pulse", vq.size(), 0);
        check("rst drop err", oerror, 0);
        cmd(WR, 0, 13'd0, 16'hBEEF);
        check("wr closed err", oerror, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sdram_responder.md
# sdram_responder

Synthesizable single-data-rate SDRAM device emulator that sits on the DRAM pin side of `sdram_controller`, in place of the external chip. It decodes the controller's command bus and tracks per-bank open rows. It stores data in a small on-chip array and returns read data with the programmed CAS latency. It is used in simulation and FPGA loopback to close the controller's read/write path without external memory, and it flags protocol violations.

## Interface
Parameters:
- ROW_BITS, 4, low row-address bits used for storage indexing
- COL_BITS, 4, low column-address bits used for storage indexing
- Storage depth is 2^(2+ROW_BITS+COL_BITS) words of 16 bits (1024 at defaults).

Ports:
- iclk  in  1  clock; all logic on the rising edge
- ireset  in  1  synchronous, active-high reset
- DRAM_CKE  in  1  clock enable; 0 freezes all state
- DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N  in  1 each  command bus
- DRAM_BA  in  2  bank address
- DRAM_ADDR  in  13  row (ACTIVE), column (READ/WRITE), A10 precharge-all flag, mode bits (LOAD MODE)
- DRAM_LDQM, DRAM_UDQM  in  1 each  write byte masks; 1 masks the byte
- dq_write  in  16  write data, sampled with the WRITE command
- dq_read  out  16  read data, registered
- odq_valid  out  1  dq_read carries a read result this cycle
- oerror  out  1  sticky protocol-violation flag
- ocas_latency  out  2  current CAS latency (2 or 3)

## Operation
- Command decode is sampled when DRAM_CKE=1. CS_N=1 means deselect (NOP). Otherwise {RAS_N,CAS_N,WE_N}: 111 NOP, 011 ACTIVE, 101 READ, 100 WRITE, 010 PRECHARGE, 001 AUTO REFRESH, 000 LOAD MODE, 110 BURST STOP (treated as NOP).
- Per bank: open flag plus open row (ROW_BITS).
- Storage index = {BA, open_row[ROW_BITS-1:0], ADDR[COL_BITS-1:0]}. Higher row and column bits are ignored (aliasing).
- ACTIVE: bank closed → open, latch row. Bank already open → set oerror, replace row.
- WRITE: bank open → write dq_write. Low byte is written unless LDQM=1; high byte is written unless UDQM=1. Bank closed → set oerror, no write.
- READ: bank open → array word captured at the command edge and pushed into the latency pipeline. Bank closed → set oerror, nothing pushed. Burst length is fixed at 1; DQM is ignored on reads.
- PRECHARGE: ADDR[10]=1 closes all banks, else closes bank BA. Precharging a closed bank is legal.
- AUTO REFRESH: any bank open → set oerror. No state change otherwise.
- LOAD MODE: any bank open → set oerror, ignored. Else ADDR[6:4]=2 or 3 sets the CAS latency; any other value sets oerror and leaves the latency unchanged.
- DRAM_CKE=0: command ignored; bank state, read pipeline, dq_read and odq_valid all hold.
- oerror stays set until reset.

## Timing
- Reset (ireset=1 at an edge): all banks closed, CAS latency=3, read pipeline flushed, dq_read=0, odq_valid=0, oerror=0. Array contents are retained and undefined after power-up. Reset overrides any command in the same cycle. Reads in flight are dropped and never appear.
- Read latency: READ accepted at edge k → dq_read valid with odq_valid=1 for exactly one cycle after edge k+CL (CL = latency at edge k). Both edges count only while CKE=1.
- The read pipeline is a 3-stage shift register. Back-to-back READs return back-to-back results in order.
- When odq_valid=0, dq_read=0.
- Write→read same address: a READ at edge k+1 returns data written at edge k. A WRITE at edge k+1 does not alter a READ captured at edge k.
- LOAD MODE changing CL while reads are in flight is impossible, because banks must be closed and reads need open banks. Reads issued before a PRECHARGE/LOAD MODE still complete with their original CL.
- No tRCD/tRP/tRFC enforcement; commands are legal on consecutive cycles.

## Test plan
- Reset, ACTIVE bank0 row0, WRITE col 0..4 with data 19..23, READ col 0..4 back-to-back → dq_read 19..23 on five consecutive cycles, each 3 cycles after its READ; oerror=0.
- LOAD MODE ADDR[6:4]=2 with banks closed, then same write/read → ocas_latency=2, data arrives 2 cycles after READ. LOAD MODE with ADDR[6:4]=5 → oerror=1, ocas_latency unchanged.
- WRITE 16'hA5C3 to bank1 row2 col7, then WRITE 16'hFFFF with LDQM=1 → READ returns 16'hFFC3. Then WRITE 16'h0000 with UDQM=1 → READ returns 16'hFF00.
- READ to closed bank2 → oerror=1 and no odq_valid pulse. ACTIVE on an already open bank → oerror=1.
- READ issued, DRAM_CKE held 0 for 4 cycles after 1 cycle → odq_valid appears only after 2 further enabled cycles, and outputs hold during the freeze.
- READ issued, ireset asserted on the next edge → odq_valid never pulses, all banks closed. A WRITE after reset without ACTIVE → oerror=1.
